// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Bundles the CPU MEM-stage port, the external host/loader port
//            and the single-port data SRAM pins that meet at dmem_arbiter.
// Modports : slave  - the arbiter (takes requests and mem_rdata, drives
//                     grants, stall, read returns and the SRAM pins)
//            master - the surrounding system (requesters and SRAM)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // CPU MEM stage
    logic              cpu_req;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // External host/loader
    logic              ext_req;
    logic              ext_wen;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_last;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    // SRAM port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_wen, ext_addr, ext_wdata, ext_last,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_addr, mem_wen, mem_ren, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_req, ext_wen, ext_addr, ext_wdata, ext_last,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_addr, mem_wen, mem_ren, mem_wdata,
        output mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the single-port data SRAM between the CPU MEM stage and
//            the external host/loader port. One grant per cycle, combinational
//            from requests and registered state; locked external bursts;
//            anti-starvation counter forces an ext grant after MAX_WAIT
//            waiting cycles; 1-cycle read data steered to the issuing owner.
// Ports    : clk  - system clock (rising edge)
//            srst - synchronous active-high reset
//            bus  - dmem_arbiter_if.slave (CPU port, ext port, SRAM pins)
// Options  : DMEM_ARB_RR_EN - when defined, simultaneous requests without
//            starvation are served round-robin instead of CPU-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            srst,
    dmem_arbiter_if.slave   bus
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_EXT_LOCK = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_wait_cnt;
    logic        r_rd_pend;
    logic        r_rd_owner;      // 0 = CPU, 1 = ext
`ifdef DMEM_ARB_RR_EN
    logic        r_last_owner;    // 0 = CPU, 1 = ext; steers round-robin ties
`endif

    logic              w_starve;
    logic              w_cpu_gnt;
    logic              w_ext_gnt;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_wen;
    logic              w_mem_ren;

    // ------------------------------------------------------------------
    // Grant decision. Reset masks every grant so nothing reaches the SRAM
    // while the arbiter state is being cleared.
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ext_gnt = 1'b0;
        w_starve  = bus.ext_req && (r_wait_cnt == c_MAX_WAIT);
        if (!srst) begin
            if (r_state == S_EXT_LOCK) begin
                // Locked burst: the CPU waits until the burst ends or aborts.
                w_ext_gnt = bus.ext_req;
            end else if (w_starve) begin
                w_ext_gnt = 1'b1;
            end else if (bus.cpu_req && bus.ext_req) begin
`ifdef DMEM_ARB_RR_EN
                w_cpu_gnt = r_last_owner;
                w_ext_gnt = ~r_last_owner;
`else
                w_cpu_gnt = 1'b1;
`endif
            end else begin
                w_cpu_gnt = bus.cpu_req;
                w_ext_gnt = bus.ext_req;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM mux. Idle cycles present the CPU address/data so the pins only
    // toggle when the CPU side changes.
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_addr  = w_ext_gnt ? bus.ext_addr  : bus.cpu_addr;
        w_mem_wdata = w_ext_gnt ? bus.ext_wdata : bus.cpu_wdata;
        w_mem_wen   = (w_cpu_gnt & bus.cpu_wen)  | (w_ext_gnt & bus.ext_wen);
        w_mem_ren   = (w_cpu_gnt & ~bus.cpu_wen) | (w_ext_gnt & ~bus.ext_wen);
    end

    // ------------------------------------------------------------------
    // State, starvation counter and read-return bookkeeping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 8'd0;
            r_rd_pend    <= 1'b0;
            r_rd_owner   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ext_gnt && !bus.ext_last) begin
                        r_state <= S_EXT_LOCK;
                    end
                end
                S_EXT_LOCK: begin
                    // Either the final beat was granted or the host dropped
                    // its request mid-burst (abort).
                    if (!bus.ext_req || bus.ext_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (!bus.ext_req || w_ext_gnt) begin
                r_wait_cnt <= 8'd0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            r_rd_pend <= w_mem_ren;
            if (w_mem_ren) begin
                r_rd_owner <= w_ext_gnt;
            end

`ifdef DMEM_ARB_RR_EN
            if (w_cpu_gnt) begin
                r_last_owner <= 1'b0;
            end else if (w_ext_gnt) begin
                r_last_owner <= 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. A read launched just before reset is discarded by masking
    // the valids with srst.
    // ------------------------------------------------------------------
    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt;
    assign bus.cpu_rvalid = r_rd_pend & ~r_rd_owner & ~srst;
    assign bus.cpu_rdata  = bus.mem_rdata;

    assign bus.ext_gnt    = w_ext_gnt;
    assign bus.ext_rvalid = r_rd_pend & r_rd_owner & ~srst;
    assign bus.ext_rdata  = bus.mem_rdata;

    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_wen    = w_mem_wen;
    assign bus.mem_ren    = w_mem_ren;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter: SRAM array, transaction-
//            level reference model compared every cycle, and directed
//            scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // SRAM (environment): 1-cycle read latency
    // ------------------------------------------------------------------
    logic [DW-1:0] sram [0:(1<<AW)-1];
    logic [DW-1:0] rdq;
    always @(posedge clk) begin
        if (bus.mem_wen) sram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_ren) rdq <= sram[bus.mem_addr];
    end
    assign bus.mem_rdata = rdq;

    // ------------------------------------------------------------------
    // Reference model: who owns the SRAM this cycle, expressed as plain
    // rules over "locked", "cycles the host has waited" and "who went last".
    // Evaluated on the falling edge, while inputs are stable.
    // ------------------------------------------------------------------
    logic [DW-1:0] mmem [0:(1<<AW)-1];
    bit            m_locked;
    int            m_wait;
    bit            m_last;
    bit            m_rd_pend;
    bit            m_rd_ext;
    logic [DW-1:0] m_rd_data;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = 32'hC0DE_0000 | 32'(i);
            mmem[i] = 32'hC0DE_0000 | 32'(i);
        end
        rdq = '0;
    end

    always @(negedge clk) begin : p_model
        bit cg, eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bit ew, er;
        cg = 0;
        eg = 0;
        if (!srst) begin
            if (m_locked)                             eg = bus.ext_req;
            else if (bus.ext_req && m_wait == MAXW)   eg = 1;
            else if (bus.cpu_req && bus.ext_req) begin
`ifdef DMEM_ARB_RR_EN
                if (m_last) cg = 1; else eg = 1;
`else
                cg = 1;
`endif
            end
            else if (bus.cpu_req)                     cg = 1;
            else if (bus.ext_req)                     eg = 1;
        end
        ea = eg ? bus.ext_addr  : bus.cpu_addr;
        ed = eg ? bus.ext_wdata : bus.cpu_wdata;
        ew = (cg && bus.cpu_wen) || (eg && bus.ext_wen);
        er = (cg && !bus.cpu_wen) || (eg && !bus.ext_wen);

        chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(cg));
        chk("ext_gnt",    32'(bus.ext_gnt),    32'(eg));
        chk("cpu_stall",  32'(bus.cpu_stall),  32'(bus.cpu_req && !cg));
        chk("mem_wen",    32'(bus.mem_wen),    32'(ew));
        chk("mem_ren",    32'(bus.mem_ren),    32'(er));
        chk("mem_addr",   32'(bus.mem_addr),   32'(ea));
        chk("mem_wdata",  bus.mem_wdata,       ed);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!srst && m_rd_pend && !m_rd_ext));
        chk("ext_rvalid", 32'(bus.ext_rvalid), 32'(!srst && m_rd_pend && m_rd_ext));
        if (!srst && m_rd_pend && !m_rd_ext) chk("cpu_rdata", bus.cpu_rdata, m_rd_data);
        if (!srst && m_rd_pend && m_rd_ext)  chk("ext_rdata", bus.ext_rdata, m_rd_data);

        // advance to the state after the coming rising edge
        if (srst) begin
            m_locked  = 0;
            m_wait    = 0;
            m_last    = 1;
            m_rd_pend = 0;
            m_rd_ext  = 0;
        end else begin
            m_rd_pend = er;
            if (er) begin
                m_rd_ext  = eg;
                m_rd_data = mmem[ea];
            end
            if (ew) mmem[ea] = ed;
            if (!bus.ext_req || eg) m_wait = 0;
            else if (m_wait < MAXW) m_wait++;
            if (m_locked) m_locked = bus.ext_req && !bus.ext_last;
            else          m_locked = eg && !bus.ext_last;
            if (cg) m_last = 0;
            if (eg) m_last = 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_set(input bit req, input bit wen, input int addr, input logic [31:0] d);
        bus.cpu_req   = req;
        bus.cpu_wen   = wen;
        bus.cpu_addr  = AW'(addr);
        bus.cpu_wdata = d;
    endtask

    task automatic ext_set(input bit req, input bit wen, input int addr,
                           input logic [31:0] d, input bit last);
        bus.ext_req   = req;
        bus.ext_wen   = wen;
        bus.ext_addr  = AW'(addr);
        bus.ext_wdata = d;
        bus.ext_last  = last;
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    bit cg_h [0:9];
    bit eg_h [0:9];
    bit st_h [0:9];
    bit ev_h [0:9];

    initial begin : p_stim
        int first_ext, ncpu, waited, ng, ns;
        srst = 1'b1;
        cpu_set(1, 0, 'h001, '0);
        ext_set(1, 0, 'h002, '0, 1);
        tick;
        tick;
        #1;
        // reset holds everything off even with both requesting
        chk("rst cpu_gnt",    32'(bus.cpu_gnt),    0);
        chk("rst ext_gnt",    32'(bus.ext_gnt),    0);
        chk("rst mem_ren",    32'(bus.mem_ren),    0);
        chk("rst mem_wen",    32'(bus.mem_wen),    0);
        chk("rst cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("rst ext_rvalid", 32'(bus.ext_rvalid), 0);

        // release with ext requesting: arbitration in the same cycle
        srst = 1'b0;
        cpu_set(0, 0, 'h000, '0);
        ext_set(1, 0, 'h005, '0, 1);
        #1;
        chk("rel ext_gnt",  32'(bus.ext_gnt),  1);
        chk("rel mem_addr", 32'(bus.mem_addr), 32'h005);
        tick;
        ext_set(0, 0, 'h000, '0, 1);
        #1;
        chk("rel ext_rvalid", 32'(bus.ext_rvalid), 1);
        chk("rel ext_rdata",  bus.ext_rdata,       32'hC0DE_0005);

        // CPU read 0x010
        tick;
        cpu_set(1, 0, 'h010, '0);
        #1;
        chk("rd cpu_gnt",   32'(bus.cpu_gnt),   1);
        chk("rd mem_ren",   32'(bus.mem_ren),   1);
        chk("rd cpu_stall", 32'(bus.cpu_stall), 0);
        tick;
        cpu_set(1, 1, 'h050, 32'h1234_5678);
        #1;
        chk("rd cpu_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("rd cpu_rdata",  bus.cpu_rdata,       32'hC0DE_0010);
        chk("wr mem_wen",    32'(bus.mem_wen),    1);
        tick;
        cpu_set(1, 0, 'h050, '0);
        tick;
        cpu_set(0, 0, 'h000, '0);
        #1;
        chk("wr readback", bus.cpu_rdata, 32'h1234_5678);

        // collision from reset: both issue single reads every cycle
        tick;
        srst = 1'b1;
        tick;
        srst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cpu_set(1, 0, 'h020 + k, '0);
            ext_set(1, 0, 'h040 + k, '0, 1);
            #1;
            cg_h[k] = bus.cpu_gnt;
            eg_h[k] = bus.ext_gnt;
            st_h[k] = bus.cpu_stall;
            ev_h[k] = bus.ext_rvalid;
            tick;
        end
        cpu_set(0, 0, 'h000, '0);
        ext_set(0, 0, 'h000, '0, 1);
`ifdef DMEM_ARB_RR_EN
        for (int k = 0; k < 10; k++) chk("rr alternation", 32'(cg_h[k]), 32'((k % 2) == 0));
`else
        first_ext = -1;
        ncpu = 0;
        for (int k = 0; k < 10; k++) begin
            if (eg_h[k] && first_ext < 0) first_ext = k;
            if (k < 8 && cg_h[k]) ncpu++;
        end
        chk("col first ext grant", 32'(first_ext), 8);
        chk("col cpu grants 0..7", 32'(ncpu), 8);
        chk("col stall at 8",      32'(st_h[8]), 1);
        chk("col ext_rvalid at 9", 32'(ev_h[9]), 1);
`endif
        tick;

        // 4-beat ext write burst with the CPU requesting throughout
        cpu_set(1, 0, 'h030, '0);
        ext_set(1, 1, 'h100, 32'hB000_0000, 0);
        waited = 0;
        #1;
        while (!bus.ext_gnt && waited < 20) begin
            tick;
            waited++;
        end
`ifdef DMEM_ARB_RR_EN
        chk("burst wait cycles", 32'(waited), 1);
`else
        chk("burst wait cycles", 32'(waited), 8);
`endif
        ng = int'(bus.ext_gnt);
        ns = int'(bus.cpu_stall);
        for (int i = 1; i < 4; i++) begin
            tick;
            ext_set(1, 1, 'h100 + i, 32'hB000_0000 + 32'(i), i == 3);
            #1;
            ng += int'(bus.ext_gnt);
            ns += int'(bus.cpu_stall);
        end
        tick;
        ext_set(0, 0, 'h000, '0, 1);
        #1;
        chk("burst ext_gnt cycles", 32'(ng), 4);
        chk("burst stall cycles",   32'(ns), 4);
        chk("burst cpu after",      32'(bus.cpu_gnt), 1);
        tick;
        cpu_set(0, 0, 'h000, '0);
        chk("burst sram 0", sram['h100], 32'hB000_0000);
        chk("burst sram 1", sram['h101], 32'hB000_0001);
        chk("burst sram 2", sram['h102], 32'hB000_0002);
        chk("burst sram 3", sram['h103], 32'hB000_0003);

        // burst abort after 2 beats
        tick;
        ext_set(1, 1, 'h200, 32'hD000_0000, 0);
        #1;
        chk("abort beat0", 32'(bus.ext_gnt), 1);
        tick;
        ext_set(1, 1, 'h201, 32'hD000_0001, 0);
        cpu_set(1, 0, 'h010, '0);
        #1;
        chk("abort beat1 stall", 32'(bus.cpu_stall), 1);
        tick;
        ext_set(0, 0, 'h000, '0, 1);
        #1;
        chk("abort drop cycle cpu_gnt", 32'(bus.cpu_gnt), 0);
        tick;
        chk("abort cpu granted", 32'(bus.cpu_gnt), 1);
        tick;
        cpu_set(0, 0, 'h000, '0);

        // reset right after an ext read grant
        tick;
        ext_set(1, 0, 'h006, '0, 1);
        #1;
        chk("rstrd ext_gnt", 32'(bus.ext_gnt), 1);
        tick;
        srst = 1'b1;
        ext_set(0, 0, 'h000, '0, 1);
        cpu_set(1, 0, 'h011, '0);
        #1;
        chk("rstrd ext_rvalid", 32'(bus.ext_rvalid), 0);
        chk("rstrd cpu_gnt",    32'(bus.cpu_gnt),    0);
        chk("rstrd mem_ren",    32'(bus.mem_ren),    0);
        tick;
        srst = 1'b0;
        #1;
        chk("rstrd cpu first cycle", 32'(bus.cpu_gnt), 1);
        tick;
        cpu_set(0, 0, 'h000, '0);
        #1;
        chk("rstrd cpu_rdata", bus.cpu_rdata, 32'hC0DE_0011);
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data SRAM between the CPU MEM stage and the external host/loader port. It owns the SRAM's address, enable and write-data pins, grants one requester per cycle and steers the 1-cycle-latency read data back to the requester that issued the read. It drives `cpu_stall`, which gates the pipeline-register enables while a CPU access waits. It also supports locked external bursts, and adds an anti-starvation counter so external traffic progresses under continuous CPU load.

## Interface
Parameters:
- `ADDR_W`, 10, SRAM word-address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 8, ext wait cycles before forced ext grant (1..255)

Ports:
- `clk` in 1 — system clock, all logic on rising edge
- `srst` in 1 — reset, synchronous, active-high
- `cpu_req` in 1 — CPU access request (MEM stage mem_read|mem_write)
- `cpu_wen` in 1 — 1 = write, 0 = read
- `cpu_addr` in ADDR_W — CPU word address
- `cpu_wdata` in DATA_W — CPU write data
- `cpu_gnt` out 1 — CPU access performed this cycle
- `cpu_stall` out 1 — `cpu_req & ~cpu_gnt`
- `cpu_rvalid` out 1 — CPU read data valid
- `cpu_rdata` out DATA_W — read data to CPU
- `ext_req` in 1 — external access request
- `ext_wen` in 1 — 1 = write
- `ext_addr` in ADDR_W — external word address
- `ext_wdata` in DATA_W — external write data
- `ext_last` in 1 — final beat of burst; 1 = single access
- `ext_gnt` out 1 — ext access performed this cycle
- `ext_rvalid` out 1 — ext read data valid
- `ext_rdata` out DATA_W — read data to ext
- `mem_addr` out ADDR_W, `mem_wen` out 1, `mem_ren` out 1, `mem_wdata` out DATA_W — SRAM port
- `mem_rdata` in DATA_W — SRAM read data, valid 1 cycle after `mem_ren`

## Operation
- States: `IDLE`, `EXT_LOCK`.
- Grants are combinational from requests and registered state. At most one grant per cycle.
- `IDLE` priority order:
  - Starvation: if `ext_req` and `wait_cnt == MAX_WAIT`, grant ext.
  - Otherwise, if `cpu_req`, grant CPU.
  - Otherwise, if `ext_req`, grant ext.
- `IDLE` → `EXT_LOCK` on ext grant with `ext_last=0`.
- `EXT_LOCK` behaviour:
  - Ext is granted whenever `ext_req=1`. CPU is never granted, so `cpu_stall` follows `cpu_req`.
  - → `IDLE` on ext grant with `ext_last=1`.
  - → `IDLE` (abort) on `ext_req=0`.
- SRAM mux:
  - On a granted access, `mem_*` carry the granted requester's addr/wdata. `mem_wen = gnt & wen`, `mem_ren = gnt & ~wen`.
  - With no grant: `mem_wen = mem_ren = 0`, and `mem_addr`/`mem_wdata` = CPU values.
- Read return:
  - Register `rd_owner` (1 bit) and `rd_pend` on each `mem_ren`.
  - Next cycle, assert `cpu_rvalid` or `ext_rvalid` per `rd_owner`.
  - `cpu_rdata = ext_rdata = mem_rdata`; they are meaningful only with the matching rvalid.
- `wait_cnt` (8-bit):
  - Increments, saturating at `MAX_WAIT`, each cycle `ext_req & ~ext_gnt`.
  - Clears on ext grant or when `ext_req=0`.
- `last_owner` register updates on every grant (0 = CPU, 1 = ext).

## Timing
- Reset values:
  - state = `IDLE`, `wait_cnt` = 0, `rd_pend` = 0, `rd_owner` = 0, `last_owner` = 1.
  - Hence all rvalids = 0. All grants and `mem_wen`/`mem_ren` are forced 0 while `srst=1`, regardless of requests.
- Grant latency 0 cycles; read data latency 1 cycle after grant; write completes in the grant cycle.
- Back-to-back grants allowed every cycle, including alternating owners. Two consecutive reads by different owners each return in order.
- Reset asserted mid-burst: next cycle `IDLE`, any pending rvalid is dropped.
- `srst` deasserted with `ext_req=1`: arbitration starts the same cycle.
- Requesters hold req/addr/wdata stable until granted.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - In `IDLE`, when both request and there is no starvation, grant the requester ≠ `last_owner` (round-robin).
  - `wait_cnt` logic is still present.
- `DMEM_ARB_RR_EN` undefined: fixed CPU priority as in Operation.

## Test plan
- CPU read only: `cpu_req=1`, `cpu_wen=0`, addr 0x010 → `cpu_gnt=1`, `mem_ren=1` same cycle. `cpu_rvalid=1` next cycle with `mem_rdata`. `cpu_stall=0`.
- Collision, RR off: both request single reads every cycle → CPU granted cycles 0..7. Ext granted at cycle 8 (`wait_cnt=8`), with `cpu_stall=1` that cycle. `ext_rvalid=1` at cycle 9.
- Collision, RR on: both request continuously from reset → grants alternate CPU, ext, CPU, ext…
- Ext burst of 4 writes (`ext_last` on beat 4), `cpu_req=1` throughout:
  - `ext_gnt` for 4 cycles and `cpu_stall=1` for 4 cycles.
  - CPU granted on cycle 5.
  - SRAM holds all 4 words.
- Burst abort: ext drops `ext_req` after 2 of 4 beats → state `IDLE` next cycle, CPU granted immediately.
- Reset mid-read: `srst=1` the cycle after an ext read grant → `ext_rvalid=0`, all grants 0. After release, a CPU request is granted in its first cycle.
